// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder
//   Memory-side end of the core's val/rdy memory request/response protocol.
//   Performs word and sub-word reads/writes on an internal word array. It
//   returns responses in acceptance order after a fixed latency, through a
//   (LATENCY-1)-deep pipeline feeding a DEPTH-entry response FIFO.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous, active-low reset
//   req_msg   : {type[66], addr[65:34], len[33:32], data[31:0]}; type 1 = write
//   req_val   : request valid
//   req_rdy   : request ready (registered state only: outstanding < DEPTH)
//   resp_msg  : {type[34], len[33:32], data[31:0]}; zero when no response queued
//   resp_val  : response valid
//   resp_rdy  : response ready
//
// Optional build macro:
//   RISCV_MEM_RAND_STALL_EN : an 8-bit LFSR randomly masks resp_val to stress
//                             the requester's tolerance of response latency.
module riscv_mem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 1,
    parameter int DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [66:0] req_msg,
    input  logic        req_val,
    output logic        req_rdy,
    output logic [34:0] resp_msg,
    output logic        resp_val,
    input  logic        resp_rdy
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic        req_type;
    logic [31:0] req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_data;
    assign {req_type, req_addr, req_len, req_data} = req_msg;

    logic [IW-1:0] word_idx;
    logic [1:0]    offset;
    logic [2:0]    nbytes;
    assign word_idx = req_addr[IW+1:2];
    assign offset   = req_addr[1:0];
    assign nbytes   = (req_len == 2'd0) ? 3'd4 : {1'b0, req_len};

    // Upper address bits are deliberately ignored so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:IW+2];

    logic [31:0] mem [MEM_WORDS];

    logic        accept;
    logic        deq;
    logic        head_vld;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] wr_shift;
    logic [31:0] rd_data;
    logic [31:0] wr_word;
    logic [3:0]  len_mask;
    logic [3:0]  wr_mask;
    logic [34:0] resp_p0;

    assign accept = req_val && req_rdy;
    assign deq    = resp_val && resp_rdy;

    // len_mask selects the low n bytes of the shifted read word; wr_mask is
    // the same mask moved up to the byte offset, truncated at byte 3 so
    // bytes that would spill past the word are simply dropped.
    always_comb begin
        rd_word  = mem[word_idx];
        len_mask = 4'((8'd1 << nbytes) - 8'd1);
        wr_mask  = 4'({4'b0000, len_mask} << offset);
        rd_shift = rd_word >> {offset, 3'b000};
        wr_shift = req_data << {offset, 3'b000};
        rd_data  = '0;
        wr_word  = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (len_mask[i]) rd_data[8*i +: 8] = rd_shift[8*i +: 8];
            if (wr_mask[i])  wr_word[8*i +: 8] = wr_shift[8*i +: 8];
        end
        resp_p0 = {req_type, req_len, req_type ? 32'd0 : rd_data};
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_type) mem[word_idx] <= wr_word;
    end

    // ---- stage p0 -> latency pipeline -> FIFO push ----
    logic        push_vld;
    logic [34:0] push_msg;

    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign push_vld = accept;
            assign push_msg = resp_p0;
        end else begin : g_pipe
            logic [LATENCY-2:0] vld_p;
            logic [34:0]        msg_p [LATENCY-1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_p <= '0;
                end else begin
                    vld_p[0] <= accept;
                    for (int k = 1; k < LATENCY - 1; k++) vld_p[k] <= vld_p[k-1];
                end
            end

            always_ff @(posedge clk) begin
                msg_p[0] <= resp_p0;
                for (int k = 1; k < LATENCY - 1; k++) msg_p[k] <= msg_p[k-1];
            end

            assign push_vld = vld_p[LATENCY-2];
            assign push_msg = msg_p[LATENCY-2];
        end
    endgenerate

    // ---- response FIFO ----
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic [34:0] fifo_msg [DEPTH];
    logic [CW-1:0] outstanding;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (deq)      rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) fifo_msg[wr_ptr[PW-1:0]] <= push_msg;
    end

    // Counts in-flight plus queued responses; capping it at DEPTH is what
    // keeps the FIFO from overflowing under back-pressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
        end else if (accept && !deq) begin
            outstanding <= outstanding + 1'b1;
        end else if (!accept && deq) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    assign req_rdy  = (outstanding < CW'(DEPTH));
    assign head_vld = (wr_ptr != rd_ptr);
    assign resp_msg = head_vld ? fifo_msg[rd_ptr[PW-1:0]] : '0;

`ifdef RISCV_MEM_RAND_STALL_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign resp_val = head_vld && (lfsr[1:0] != 2'b00);
`else
    assign resp_val = head_vld;
`endif

endmodule

// File: tb/tb_riscv_mem_responder.sv
module tb_riscv_mem_responder;

    logic        clk;
    logic        reset;
    logic [66:0] req_msg;
    logic        req_val;
    logic        req_rdy;
    logic [34:0] resp_msg;
    logic        resp_val;
    logic        resp_rdy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stalls   = 0;

    logic [34:0] exp_q[$];
    int          resp_cyc_q[$];

    riscv_mem_responder #(
        .MEM_WORDS(1024),
        .LATENCY  (1),
        .DEPTH    (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req_msg (req_msg),
        .req_val (req_val),
        .req_rdy (req_rdy),
        .resp_msg(resp_msg),
        .resp_val(resp_val),
        .resp_rdy(resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response handshake pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (reset && resp_val && resp_rdy) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 64'(resp_msg), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("resp_msg", 64'(resp_msg), 64'(exp_q.pop_front()));
                resp_cyc_q.push_back(cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input bit typ, input logic [31:0] addr, input logic [1:0] len,
                        input logic [31:0] data, input logic [34:0] exp);
        int guard = 0;
        req_msg = {typ, addr, len, data};
        req_val = 1'b1;
        @(negedge clk);
        while (!req_rdy && guard < 50) begin
            stalls++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) chk("send_timeout", 64'(guard), 64'd0);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        req_val = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk(tag, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_addr [4];
    logic [31:0] bp_val  [4];
    int          accepts;
    int          idx;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_val", 64'(resp_val), 64'd0);
        chk("rst_resp_msg", 64'(resp_msg), 64'd0);
        chk("rst_req_rdy",  64'(req_rdy),  64'd1);
        reset = 1'b1;

        // Preload word 0x10 through the write path.
        send(1'b1, 32'h40, 2'd0, 32'hDEADBEEF, {1'b1, 2'd0, 32'd0});
        wait_drain("drain_preload");

        // Full-word read, first response one cycle after acceptance.
        chk("idle_resp_val", 64'(resp_val), 64'd0);
        send(1'b0, 32'h40, 2'd0, 32'd0, {1'b0, 2'd0, 32'hDEADBEEF});
        chk("lat1_resp_val", 64'(resp_val), 64'd1);
        wait_drain("drain_lat");

        // Sub-word reads, sub-word write, boundary-crossing accesses.
        send(1'b0, 32'h43, 2'd1, 32'd0, {1'b0, 2'd1, 32'h000000DE});
        send(1'b0, 32'h42, 2'd2, 32'd0, {1'b0, 2'd2, 32'h0000DEAD});
        send(1'b1, 32'h41, 2'd2, 32'h00001234, {1'b1, 2'd2, 32'd0});
        send(1'b0, 32'h40, 2'd0, 32'd0, {1'b0, 2'd0, 32'hDE1234EF});
        send(1'b0, 32'h43, 2'd2, 32'd0, {1'b0, 2'd2, 32'h000000DE});
        send(1'b1, 32'h43, 2'd0, 32'h11223344, {1'b1, 2'd0, 32'd0});
        send(1'b0, 32'h40, 2'd0, 32'd0, {1'b0, 2'd0, 32'h441234EF});
        send(1'b0, 32'h41, 2'd3, 32'd0, {1'b0, 2'd3, 32'h00441234});
        wait_drain("drain_subword");

        // Back-to-back writes then reads at full throughput.
        stalls = 0;
        send(1'b1, 32'h100, 2'd0, 32'd1, {1'b1, 2'd0, 32'd0});
        send(1'b1, 32'h104, 2'd0, 32'd2, {1'b1, 2'd0, 32'd0});
        send(1'b1, 32'h108, 2'd0, 32'd3, {1'b1, 2'd0, 32'd0});
        wait_drain("drain_b2b_wr");
        resp_cyc_q.delete();
        send(1'b0, 32'h100, 2'd0, 32'd0, {1'b0, 2'd0, 32'd1});
        send(1'b0, 32'h104, 2'd0, 32'd0, {1'b0, 2'd0, 32'd2});
        send(1'b0, 32'h108, 2'd0, 32'd0, {1'b0, 2'd0, 32'd3});
        wait_drain("drain_b2b_rd");
        chk("b2b_no_stall", 64'(stalls), 64'd0);
        chk("b2b_resp_count", 64'(resp_cyc_q.size()), 64'd3);
        if (resp_cyc_q.size() == 3)
            chk("b2b_consecutive", 64'(resp_cyc_q[2] - resp_cyc_q[0]), 64'd2);

        // Back-pressure: hold requests with responses blocked.
        bp_addr[0] = 32'h100; bp_val[0] = 32'd1;
        bp_addr[1] = 32'h104; bp_val[1] = 32'd2;
        bp_addr[2] = 32'h108; bp_val[2] = 32'd3;
        bp_addr[3] = 32'h040; bp_val[3] = 32'h441234EF;
        resp_rdy = 1'b0;
        accepts  = 0;
        req_msg  = {1'b0, bp_addr[0], 2'd0, 32'd0};
        req_val  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (req_rdy) begin
                idx = (accepts < 4) ? accepts : 0;
                exp_q.push_back({1'b0, 2'd0, bp_val[idx]});
                accepts++;
            end
            @(posedge clk);
            #1;
            idx = (accepts < 4) ? accepts : 0;
            req_msg = {1'b0, bp_addr[idx], 2'd0, 32'd0};
        end
        req_val = 1'b0;
        chk("bp_accepts",   64'(accepts),  64'd4);
        chk("bp_req_rdy_0", 64'(req_rdy),  64'd0);
        chk("bp_resp_val",  64'(resp_val), 64'd1);
        chk("bp_head_msg",  64'(resp_msg), 64'({1'b0, 2'd0, 32'd1}));
        resp_rdy = 1'b1;
        chk("bp_req_rdy_pre", 64'(req_rdy), 64'd0);
        @(posedge clk);
        #1;
        chk("bp_req_rdy_after", 64'(req_rdy), 64'd1);
        wait_drain("drain_bp");

        // Address wrap modulo MEM_WORDS.
        send(1'b1, 32'h1000, 2'd0, 32'hA5A5A5A5, {1'b1, 2'd0, 32'd0});
        send(1'b0, 32'h0000, 2'd0, 32'd0, {1'b0, 2'd0, 32'hA5A5A5A5});
        wait_drain("drain_wrap");

        // Reset with responses queued.
        resp_rdy = 1'b0;
        send(1'b0, 32'h100, 2'd0, 32'd0, {1'b0, 2'd0, 32'd1});
        send(1'b0, 32'h104, 2'd0, 32'd0, {1'b0, 2'd0, 32'd2});
        send(1'b0, 32'h108, 2'd0, 32'd0, {1'b0, 2'd0, 32'd3});
        chk("pre_rst_resp_val", 64'(resp_val), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_resp_val", 64'(resp_val), 64'd0);
        chk("mid_rst_req_rdy",  64'(req_rdy),  64'd1);
        chk("mid_rst_resp_msg", 64'(resp_msg), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        resp_rdy = 1'b1;
        send(1'b0, 32'h0000, 2'd0, 32'd0, {1'b0, 2'd0, 32'hA5A5A5A5});
        send(1'b0, 32'h0040, 2'd0, 32'd0, {1'b0, 2'd0, 32'h441234EF});
        wait_drain("drain_post_rst");
        chk("post_rst_idle", 64'(resp_val), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
- Single-port memory responder: the memory-side end of the core's val/rdy memory request / response protocol.
- Accepts packed 67-bit request messages, performs word or sub-word reads and writes on an internal word array, and returns packed 35-bit responses in order after a fixed latency.
- Test harnesses instantiate one per core port (imem, dmem) in place of the behavioural test memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words; power of two.
- LATENCY, 1, cycles from request acceptance to earliest resp_val; legal range 1..4.
- DEPTH, 4, maximum outstanding requests (in flight plus queued responses); power of two, >= LATENCY.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_msg  in  67  request message {type[66], addr[65:34], len[33:32], data[31:0]}; type 0=read, 1=write.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- resp_msg  out  35  response message {type[34], len[33:32], data[31:0]}.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready; the core ties this high.

Behaviour:
- Reset (reset==0, asynchronous):
  - clears the latency pipeline, response FIFO pointers and outstanding counter.
  - resp_val=0, resp_msg=0, req_rdy=1.
  - Memory array is not reset; benches preload it with $readmemh.
- Transactions:
  - Accept when req_val && req_rdy; response dequeued when resp_val && resp_rdy.
  - req_rdy = (outstanding < DEPTH); purely a function of registered state, no combinational path from req_val or resp_rdy.
- Outstanding counter:
  - +1 on accept, -1 on dequeue; unchanged when both occur in the same cycle.
  - Counter width is clog2(DEPTH)+1; it never exceeds DEPTH.
  - At full, accept and dequeue in the same cycle is not allowed, because req_rdy=0.
- Addressing:
  - word index = addr[clog2(MEM_WORDS)+1:2]; upper address bits are ignored, so accesses wrap modulo MEM_WORDS.
  - offset = addr[1:0].
  - Byte count n = len, with len==0 meaning 4 bytes.
- Read (array access in the accept cycle):
  - data = (word >> 8*offset) masked to the low n bytes; upper bytes are zero.
  - Sign extension is the requester's job.
  - Bytes that would cross the word boundary read as zero.
- Write (array updated at the accept edge):
  - byte i of the word is written with req data byte (i-offset) for offset <= i < offset+n and i <= 3.
  - Bytes beyond byte 3 are dropped.
  - Response data = 0.
- Ordering:
  - Response type and len echo the request.
  - A write accepted in cycle c is visible to a read accepted in cycle c+1 or later.
  - Responses return strictly in acceptance order.
- Latency:
  - The response passes through LATENCY-1 pipeline registers into a DEPTH-entry FIFO.
  - A request accepted in cycle c gives resp_val=1 in cycle c+LATENCY if the FIFO is empty.
  - With resp_rdy held high and LATENCY=1, the block sustains one accept and one response per cycle.
- Back-pressure: while resp_rdy==0, resp_msg and resp_val stay stable; the pipeline keeps draining into the FIFO, which cannot overflow because of the outstanding limit.
- FIFO pointers wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.
- Reset asserted mid-operation discards all in-flight responses; memory writes already performed are retained.

Optional Feature:
- Macro: RISCV_MEM_RAND_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle.
  - resp_val is forced to 0 whenever lfsr[1:0]==2'b00; dequeue only happens when the masked resp_val is 1.
  - Used to stress the requester's tolerance of response latency.
- Undefined: no LFSR, no masking; timing is exactly as in Behaviour.

Test Plan:
- Preload word 0x10 = 0xDEADBEEF; LATENCY=1; read addr 0x40 len 0 accepted in cycle 5 -> resp_val in cycle 6, resp_msg = {0, 2'd0, 32'hDEADBEEF}.
- Sub-word reads and write:
  - Read addr 0x43 len 1 -> data 0x000000DE.
  - Read addr 0x42 len 2 -> data 0x0000DEAD.
  - Write addr 0x41 len 2 data 0x00001234, then read addr 0x40 len 0 -> 0xDE1234EF.
  - The write response is {1, 2'd2, 0}.
- Back-back writes then reads: write 0x100/0x104/0x108 = 1/2/3, then read all three with resp_rdy=1 -> responses 1, 2, 3 in consecutive cycles, no req_rdy drop.
- Back-pressure:
  - DEPTH=4, resp_rdy=0, req_val held high -> exactly 4 accepts, then req_rdy=0.
  - Raise resp_rdy -> 4 responses in order, and req_rdy returns 1 the cycle after the first dequeue.
- Wrap-around: MEM_WORDS=1024; write addr 0x1000 = 0xA5A5A5A5, then read addr 0x0 -> 0xA5A5A5A5.
- Reset mid-operation: with 3 responses queued, pulse reset low -> resp_val=0 immediately, req_rdy=1. A subsequent read of a previously written word returns the written value.
